// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host I2C commands and issues them one at a time to i2c_master
module i2c_cmd_sequencer #(
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 2,
  parameter int ST_WIDTH = 1 + ADDR_BYTES + DATA_BYTES,
  parameter int REG_ADDR_WIDTH = 8 * ADDR_BYTES,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rw,
  input  logic                      cmd_mode,
  input  logic [6:0]                cmd_chip_addr,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_reg_addr,
  input  logic [8*DATA_BYTES-1:0]   cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ST_WIDTH-1:0]       rsp_status,
  output logic [8*DATA_BYTES-1:0]   rsp_data,
  output logic                      rsp_nack,
  output logic                      rsp_timeout,
  output logic                      seq_busy,
  output logic [6:0]                m_chip_addr,
  output logic [REG_ADDR_WIDTH-1:0] m_reg_addr,
  output logic [8*DATA_BYTES-1:0]   m_data_in,
  output logic                      m_write_en,
  output logic                      m_write_mode,
  output logic                      m_read_en,
  input  logic                      m_done,
  input  logic                      m_busy,
  input  logic [ST_WIDTH-1:0]       m_status,
  input  logic [8*DATA_BYTES-1:0]   m_data_out
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int EW = 2 + 7 + REG_ADDR_WIDTH + DW;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;
  state_t state;
  logic [EW-1:0] mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [TW-1:0] timer;
  logic rw, push, pop;
  assign push = cmd_valid & cmd_ready;
  assign pop = (state == IDLE) & (count != '0) & ~m_busy;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign seq_busy = (state != IDLE) | (count != '0);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_rw, cmd_mode, cmd_chip_addr, cmd_reg_addr, cmd_data};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cmd_ready <= 1'b1;
      timer <= '0;
      rw <= 1'b0;
      m_chip_addr <= '0;
      m_reg_addr <= '0;
      m_data_in <= '0;
      m_write_en <= 1'b0;
      m_write_mode <= 1'b0;
      m_read_en <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_status <= '0;
      rsp_data <= '0;
      rsp_nack <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      cmd_ready <= count_nxt != CW'(CMD_DEPTH);
      m_write_en <= 1'b0;
      m_read_en <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          {rw, m_write_mode, m_chip_addr, m_reg_addr, m_data_in} <= mem[rd_ptr];
          state <= ISSUE;
        end
        ISSUE: begin
          m_read_en <= rw;
          m_write_en <= ~rw;
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          timer <= timer + TW'(1);
          // a done arriving on the last allowed cycle still counts as success
          if (m_done) begin
            rsp_status <= m_status;
            rsp_data <= rw ? m_data_out : '0;
            rsp_nack <= |m_status;
            rsp_timeout <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_status <= '0;
            rsp_data <= '0;
            rsp_nack <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
